// File: rtl/soc_test_monitor.sv
// Test harness monitor: holds the SoC in reset, watches per-hart tohost stores
// and latches a sticky pass/fail/timeout verdict with the run cycle count.
module soc_test_monitor #(
  parameter int unsigned NUM_HARTS      = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RST_CYCLES     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = ADDR_WIDTH'(32'h0000_1000)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_HARTS-1:0]             wr_valid,
  input  logic [NUM_HARTS*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_HARTS*DATA_WIDTH-1:0]  wr_data,
  output logic                             core_rst,
  output logic [31:0]                      cycle_count,
  output logic                             done,
  output logic                             pass,
  output logic                             fail,
  output logic                             timeout,
  output logic [DATA_WIDTH-2:0]            fail_code,
  output logic [2:0]                       done_hart
);

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST    = HW'(RST_CYCLES - 1);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic                  core_rst_q, core_rst_d;
  logic [31:0]           cycle_count_q, cycle_count_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  timeout_q, timeout_d;
  logic [DATA_WIDTH-2:0] fail_code_q, fail_code_d;
  logic [2:0]            done_hart_q, done_hart_d;

  logic                  sel_valid;
  logic [2:0]            sel_idx;
  logic [DATA_WIDTH-1:0] sel_data;

  // Only odd-data tohost stores qualify; scanning downward lets the lowest hart win.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_data  = '0;
    for (int i = int'(NUM_HARTS) - 1; i >= 0; i--) begin
      if (wr_valid[i] && (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == TOHOST_ADDR)
          && wr_data[i*DATA_WIDTH]) begin
        sel_valid = 1'b1;
        sel_idx   = 3'(i);
        sel_data  = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    core_rst_d    = core_rst_q;
    cycle_count_d = cycle_count_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    timeout_d     = timeout_q;
    fail_code_d   = fail_code_q;
    done_hart_d   = done_hart_q;
    case (state_q)
      S_HOLD: begin
        core_rst_d = 1'b1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_RUN;
          core_rst_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        core_rst_d = 1'b0;
        if (cycle_count_q != 32'hFFFF_FFFF) cycle_count_d = cycle_count_q + 32'd1;
        // A qualifying store in the timeout cycle still decides the verdict.
        if (sel_valid) begin
          state_d     = S_DONE;
          core_rst_d  = 1'b1;
          done_d      = 1'b1;
          done_hart_d = sel_idx;
          if (sel_data == DATA_WIDTH'(1)) begin
            pass_d = 1'b1;
          end else begin
            fail_d      = 1'b1;
            fail_code_d = sel_data[DATA_WIDTH-1:1];
          end
        end else if (cycle_count_q == TIMEOUT_LAST) begin
          state_d    = S_DONE;
          core_rst_d = 1'b1;
          done_d     = 1'b1;
          timeout_d  = 1'b1;
        end
      end
      S_DONE: begin
        core_rst_d = 1'b1;
      end
      default: begin
        state_d    = S_HOLD;
        core_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HOLD;
      hold_cnt_q    <= '0;
      core_rst_q    <= 1'b1;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_code_q   <= '0;
      done_hart_q   <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      core_rst_q    <= core_rst_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
      fail_code_q   <= fail_code_d;
      done_hart_q   <= done_hart_d;
    end
  end

  assign core_rst    = core_rst_q;
  assign cycle_count = cycle_count_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_code_q;
  assign done_hart   = done_hart_q;

endmodule

// File: tb/tb_soc_test_monitor.sv
// Scoreboard bench for soc_test_monitor: per-run write plans are turned into an
// expected verdict by a reference model; a monitor compares it when done rises.
module tb_soc_test_monitor;

  localparam int NH   = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int RC   = 10;
  localparam int TC   = 120;
  localparam int MAXC = TC + 16;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic             clk = 1'b0;
  logic             rst;
  logic [NH-1:0]    wr_valid;
  logic [NH*AW-1:0] wr_addr;
  logic [NH*DW-1:0] wr_data;
  logic             core_rst;
  logic [31:0]      cycle_count;
  logic             done, pass, fail, timeout;
  logic [DW-2:0]    fail_code;
  logic [2:0]       done_hart;

  soc_test_monitor #(
    .NUM_HARTS(NH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .RST_CYCLES(RC), .TIMEOUT_CYCLES(TC), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_rst(core_rst), .cycle_count(cycle_count), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .fail_code(fail_code), .done_hart(done_hart)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          pass;
    logic          fail;
    logic          tmo;
    logic [DW-2:0] code;
    logic [2:0]    hart;
    logic [31:0]   count;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done_prev = 1'b0;

  logic          p_valid [0:MAXC-1][0:NH-1];
  logic [AW-1:0] p_addr  [0:MAXC-1][0:NH-1];
  logic [DW-1:0] p_data  [0:MAXC-1][0:NH-1];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Verdict = first odd store to tohost in time order (lowest hart within a
  // cycle) up to the last pre-timeout cycle; otherwise a timeout.
  function automatic res_t model();
    res_t r;
    r = '0;
    for (int rc = 0; rc < TC; rc++) begin
      for (int h = 0; h < NH; h++) begin
        if (p_valid[rc][h] && p_addr[rc][h] == TOHOST && (p_data[rc][h] % 2 == 1)) begin
          r.hart  = 3'(h);
          r.count = 32'(rc + 1);
          if (p_data[rc][h] == 1) r.pass = 1'b1;
          else begin
            r.fail = 1'b1;
            r.code = (DW-1)'(p_data[rc][h] / 2);
          end
          return r;
        end
      end
    end
    r.tmo   = 1'b1;
    r.count = 32'(TC);
    return r;
  endfunction

  function automatic res_t actual();
    return {pass, fail, timeout, fail_code, done_hart, cycle_count};
  endfunction

  // Monitor: compares the oldest expected verdict whenever done rises.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done && !done_prev) begin
        checkOutput("exp_available", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) checkOutput("result", actual(), exp_q.pop_front());
        checkOutput("done_core_rst", core_rst, 1);
        checkOutput("done_is_or", done, pass | fail | timeout);
      end
      done_prev = done;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic driveIdle();
    wr_valid = '0;
    wr_addr  = '0;
    wr_data  = '0;
  endtask

  task automatic driveCycle(input int rc);
    for (int h = 0; h < NH; h++) begin
      wr_valid[h]          = p_valid[rc][h];
      wr_addr[h*AW +: AW]  = p_addr[rc][h];
      wr_data[h*DW +: DW]  = p_data[rc][h];
    end
  endtask

  task automatic clearPlan();
    for (int rc = 0; rc < MAXC; rc++)
      for (int h = 0; h < NH; h++) begin
        p_valid[rc][h] = 1'b0;
        p_addr[rc][h]  = TOHOST;
        p_data[rc][h]  = 32'd1;
      end
  endtask

  task automatic setWrite(input int rc, input int h, input logic [31:0] a, input logic [31:0] d);
    p_valid[rc][h] = 1'b1;
    p_addr[rc][h]  = a;
    p_data[rc][h]  = d;
  endtask

  task automatic genRandom(input int odd_pct);
    int sel;
    clearPlan();
    for (int rc = 0; rc < MAXC; rc++)
      for (int h = 0; h < NH; h++) begin
        if ($urandom_range(0, 99) < 8) begin
          sel = int'($urandom_range(0, 3));
          p_valid[rc][h] = 1'b1;
          p_addr[rc][h]  = (sel == 0) ? TOHOST + 32'd4 : (sel == 3) ? $urandom : TOHOST;
          p_data[rc][h]  = $urandom & 32'hFFFF_FFFE;
          if ($urandom_range(0, 99) < odd_pct)
            p_data[rc][h] = ($urandom_range(0, 3) == 0) ? 32'd1 : (p_data[rc][h] | 32'd1);
        end
      end
  endtask

  // One run: reset, hold-length check, replay the plan, then confirm DONE ignores stores.
  task automatic applyStimulus(input int rst_len, input bit hold_write, input int abort_at);
    res_t e;
    int   hc;
    bit   seen;
    @(negedge clk);
    rst = 1'b1;
    driveIdle();
    repeat (rst_len) @(posedge clk);
    #1;
    checkOutput("reset_state",
                {core_rst, done, pass, fail, timeout, cycle_count, fail_code, done_hart},
                {1'b1, 70'd0});
    @(negedge clk);
    rst = 1'b0;
    if (hold_write) begin
      wr_valid[0]    = 1'b1;
      wr_addr[AW-1:0] = TOHOST;
      wr_data[DW-1:0] = 32'd1;
    end
    hc = 1;
    for (int k = 0; k < RC + 20; k++) begin
      @(posedge clk);
      #1;
      if (core_rst !== 1'b1) break;
      hc++;
    end
    checkOutput("hold_len", hc, RC);
    checkOutput("run_start", {done, cycle_count}, 0);
    if (abort_at < 0) begin
      e = model();
      exp_q.push_back(e);
    end
    seen = 1'b0;
    for (int rc = 0; rc < MAXC; rc++) begin
      if (abort_at >= 0 && rc == abort_at) break;
      @(negedge clk);
      driveCycle(rc);
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (abort_at >= 0) begin
      checkOutput("abort_count", cycle_count, abort_at);
      return;
    end
    checkOutput("done_seen", seen, 1);
    repeat (4) begin
      @(negedge clk);
      wr_valid = '1;
      for (int h = 0; h < NH; h++) begin
        wr_addr[h*AW +: AW] = TOHOST;
        wr_data[h*DW +: DW] = (h == 0) ? 32'd1 : 32'd3;
      end
      @(posedge clk);
    end
    #1;
    checkOutput("sticky", actual(), e);
    checkOutput("sticky_core_rst", core_rst, 1);
    checkOutput("sb_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    driveIdle();
    repeat (2) @(posedge clk);

    clearPlan();
    setWrite(10, 0, TOHOST + 32'd4, 32'd1);
    setWrite(20, 1, TOHOST + 32'd4, 32'd1);
    setWrite(100, 0, TOHOST, 32'd1);
    applyStimulus(3, 1'b1, -1);

    clearPlan();
    setWrite(30, 1, TOHOST, 32'h0B);
    setWrite(30, 0, TOHOST, 32'h04);
    setWrite(30, 2, TOHOST, 32'h01);
    applyStimulus(3, 1'b0, -1);

    clearPlan();
    setWrite(5, 0, TOHOST, 32'd2);
    applyStimulus(2, 1'b0, -1);

    clearPlan();
    setWrite(TC - 1, 2, TOHOST, 32'd1);
    applyStimulus(2, 1'b0, -1);

    clearPlan();
    setWrite(TC - 1, 1, TOHOST, 32'd7);
    applyStimulus(1, 1'b0, -1);

    clearPlan();
    setWrite(100, 0, TOHOST, 32'd1);
    applyStimulus(2, 1'b0, 50);

    clearPlan();
    setWrite(40, 0, TOHOST, 32'd1);
    applyStimulus(1, 1'b0, -1);

    for (int n = 0; n < 15; n++) begin
      genRandom(int'($urandom_range(0, 12)));
      applyStimulus(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
